// File: rtl/tone_pkg.sv
// Shared sizes, step-record layout and state encoding for the tone sequencer.
package tone_pkg;

  localparam int unsigned STEPS = 8;
  localparam int unsigned DUR_W = 8;
  localparam int unsigned IDX_W = $clog2(STEPS);
  localparam int unsigned REC_W = 4 + DUR_W;

  // Step record layout: {hl, sw[2:0], dur[DUR_W-1:0]}
  localparam int unsigned HL_BIT  = REC_W - 1;
  localparam int unsigned SW_MSB  = REC_W - 2;
  localparam int unsigned SW_LSB  = DUR_W;
  localparam int unsigned DUR_MSB = DUR_W - 1;
  localparam int unsigned DUR_LSB = 0;

  typedef struct packed {
    logic             hl;
    logic [2:0]       sw;
    logic [DUR_W-1:0] dur;
  } step_rec_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/step_table.sv
// Tone step table: synchronous write port, asynchronous read port.
module step_table
  import tone_pkg::*;
(
  input  logic             clk,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_addr,
  input  logic [REC_W-1:0] wr_data,
  input  logic [IDX_W-1:0] rd_addr,
  output logic [REC_W-1:0] rd_data_c
);

  logic [REC_W-1:0] mem [STEPS];

  // Storage is not reset; software programs it before playback.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data_c = mem[rd_addr];

endmodule

// File: rtl/tone_sequencer.sv
// Steps the frequency divider through a programmed tone list and makes the square wave.
module tone_sequencer
  import tone_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_addr,
  input  logic [REC_W-1:0] wr_data,
  input  logic [IDX_W-1:0] last_idx,
  input  logic             loop,
  input  logic             start,
  input  logic             stop,
  input  logic             div_co,
  output logic             div_init,
  output logic             div_hl,
  output logic [2:0]       div_sw,
  output logic             tone_out,
  output logic             busy,
  output logic             done,
  output logic [IDX_W-1:0] step_idx
);

  state_t           state_q, state_d;
  logic [DUR_W-1:0] dur_q, dur_d;
  logic [IDX_W-1:0] idx_d;
  logic             hl_d, init_d, tone_d, busy_d, done_d;
  logic [2:0]       sw_d;
  logic [REC_W-1:0] rd_data_c;
  step_rec_t        rec;

  step_table u_table (
    .clk      (clk),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rd_addr  (step_idx),
    .rd_data_c(rd_data_c)
  );

  assign rec = '{hl:  rd_data_c[HL_BIT],
                 sw:  rd_data_c[SW_MSB:SW_LSB],
                 dur: rd_data_c[DUR_MSB:DUR_LSB]};

  // Next-state and next-output logic.
  always_comb begin
    state_d = state_q;
    idx_d   = step_idx;
    dur_d   = dur_q;
    hl_d    = div_hl;
    sw_d    = div_sw;
    tone_d  = tone_out;
    init_d  = 1'b1;
    case (state_q)
      IDLE: begin
        tone_d = 1'b0;
        if (start && !stop) begin
          state_d = LOAD;
          idx_d   = '0;
        end
      end
      LOAD: begin
        if (stop) begin
          state_d = IDLE;
          tone_d  = 1'b0;
          idx_d   = '0;
        end else begin
          hl_d    = rec.hl;
          sw_d    = rec.sw;
          dur_d   = rec.dur;
          state_d = RUN;
        end
      end
      RUN: begin
        if (stop) begin
          state_d = IDLE;
          tone_d  = 1'b0;
          idx_d   = '0;
        end else if (!div_co) begin
          init_d = 1'b0;
        end else begin
          tone_d = ~tone_out;
          if (dur_q != DUR_W'(1)) begin
            // dur of zero wraps here, giving 2^DUR_W pulses
            dur_d  = dur_q - DUR_W'(1);
            init_d = 1'b0;
          end else if (step_idx != last_idx) begin
            idx_d   = step_idx + IDX_W'(1);
            state_d = LOAD;
          end else if (loop) begin
            idx_d   = '0;
            state_d = LOAD;
          end else begin
            tone_d  = 1'b0;
            state_d = DONE;
          end
        end
      end
      DONE: begin
        tone_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        tone_d  = 1'b0;
      end
    endcase
    busy_d = (state_d == LOAD) || (state_d == RUN);
    done_d = (state_d == DONE);
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      step_idx <= '0;
      dur_q    <= '0;
      div_init <= 1'b1;
      div_hl   <= 1'b0;
      div_sw   <= 3'd0;
      tone_out <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state_q  <= state_d;
      step_idx <= idx_d;
      dur_q    <= dur_d;
      div_init <= init_d;
      div_hl   <= hl_d;
      div_sw   <= sw_d;
      tone_out <= tone_d;
      busy     <= busy_d;
      done     <= done_d;
    end
  end

endmodule

// File: tb/tb_tone_sequencer.sv
// Self-checking bench for tone_sequencer with a behavioural divider and step-list model.
module tb_tone_sequencer;

  logic        clk;
  logic        rst;
  logic        wr_en;
  logic [2:0]  wr_addr;
  logic [11:0] wr_data;
  logic [2:0]  last_idx;
  logic        loop;
  logic        start;
  logic        stop;
  logic        div_co;
  logic        div_init;
  logic        div_hl;
  logic [2:0]  div_sw;
  logic        tone_out;
  logic        busy;
  logic        done;
  logic [2:0]  step_idx;

  int n_cmp = 0;
  int n_err = 0;

  // Bench copy of what was programmed into the table
  int tb_hl  [8];
  int tb_sw  [8];
  int tb_dur [8];

  tone_sequencer dut (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .last_idx(last_idx),
    .loop    (loop),
    .start   (start),
    .stop    (stop),
    .div_co  (div_co),
    .div_init(div_init),
    .div_hl  (div_hl),
    .div_sw  (div_sw),
    .tone_out(tone_out),
    .busy    (busy),
    .done    (done),
    .step_idx(step_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int per_of(int h, int s);
    return 512 - (h * 256 + s * 32);
  endfunction

  function automatic int eff_dur(int d);
    return (d == 0) ? 256 : d;
  endfunction

  // Divider model: one-cycle carry every P clocks once init is low
  int dcnt = 0;
  always @(negedge clk) begin
    if (div_init !== 1'b0) begin
      dcnt   = 0;
      div_co = 1'b0;
    end else begin
      dcnt = dcnt + 1;
      if (dcnt >= per_of(int'(div_hl), int'(div_sw))) begin
        div_co = 1'b1;
        dcnt   = 0;
      end else begin
        div_co = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Wait for the next carry and check how many clocks it took
  task automatic wait_co(int exp_gap, string tag);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (div_co !== 1'b1 && n < 2000);
    chk({tag, "/co_gap"}, 32'(n), 32'(exp_gap));
  endtask

  task automatic wr(int a, int h, int s, int d);
    wr_en   = 1'b1;
    wr_addr = 3'(a);
    wr_data = {1'(h), 3'(s), 8'(d)};
    tick();
    wr_en   = 1'b0;
    tb_hl[a]  = h;
    tb_sw[a]  = s;
    tb_dur[a] = d;
  endtask

  // Play steps 0..nsteps-1 and check every carry against the step list
  task automatic play(int nsteps, bit lp, int passes, string tag);
    int tot;
    int e;
    tot      = 0;
    last_idx = 3'(nsteps - 1);
    loop     = lp;
    start    = 1'b1;
    tick();
    start    = 1'b0;
    chk({tag, "/busy_start"}, 32'(busy), 1);
    chk({tag, "/init_start"}, 32'(div_init), 1);
    for (int p = 0; p < passes; p++) begin
      for (int s = 0; s < nsteps; s++) begin
        tick();
        chk({tag, "/idx_load"}, 32'(step_idx), 32'(s));
        chk({tag, "/hl_load"}, 32'(div_hl), 32'(tb_hl[s]));
        chk({tag, "/sw_load"}, 32'(div_sw), 32'(tb_sw[s]));
        chk({tag, "/init_load"}, 32'(div_init), 1);
        e = eff_dur(tb_dur[s]);
        for (int c = 1; c <= e; c++) begin
          wait_co((c == 1) ? per_of(tb_hl[s], tb_sw[s]) + 1 : per_of(tb_hl[s], tb_sw[s]), tag);
          tot++;
          if (c < e) begin
            chk({tag, "/tone"}, 32'(tone_out), 32'(tot % 2));
            chk({tag, "/idx_run"}, 32'(step_idx), 32'(s));
          end else if (s < nsteps - 1 || lp) begin
            chk({tag, "/tone_end"}, 32'(tone_out), 32'(tot % 2));
            chk({tag, "/no_done"}, 32'(done), 0);
            chk({tag, "/busy_mid"}, 32'(busy), 1);
            chk({tag, "/idx_next"}, 32'(step_idx), 32'((s == nsteps - 1) ? 0 : s + 1));
          end else begin
            chk({tag, "/done"}, 32'(done), 1);
            chk({tag, "/busy_end"}, 32'(busy), 0);
            chk({tag, "/tone_done"}, 32'(tone_out), 0);
            chk({tag, "/init_done"}, 32'(div_init), 1);
            tick();
            chk({tag, "/done_pulse"}, 32'(done), 0);
            chk({tag, "/busy_idle"}, 32'(busy), 0);
          end
        end
      end
    end
  endtask

  task automatic do_stop(string tag);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk({tag, "/stop_busy"}, 32'(busy), 0);
    chk({tag, "/stop_done"}, 32'(done), 0);
    chk({tag, "/stop_tone"}, 32'(tone_out), 0);
    chk({tag, "/stop_idx"}, 32'(step_idx), 0);
    chk({tag, "/stop_init"}, 32'(div_init), 1);
  endtask

  initial begin
    int n;
    int h;
    bit lp;
    int saw_done;
    rst      = 1'b0;
    wr_en    = 1'b0;
    wr_addr  = 3'd0;
    wr_data  = 12'd0;
    last_idx = 3'd0;
    loop     = 1'b0;
    start    = 1'b0;
    stop     = 1'b0;
    div_co   = 1'b0;

    // Reset state, then idle after release
    repeat (3) tick();
    chk("rst/init", 32'(div_init), 1);
    chk("rst/tone", 32'(tone_out), 0);
    chk("rst/busy", 32'(busy), 0);
    chk("rst/done", 32'(done), 0);
    chk("rst/idx", 32'(step_idx), 0);
    chk("rst/hl_sw", 32'({div_hl, div_sw}), 0);
    rst = 1'b1;
    repeat (20) tick();
    chk("idle/init", 32'(div_init), 1);
    chk("idle/tone", 32'(tone_out), 0);
    chk("idle/busy", 32'(busy), 0);
    chk("idle/done", 32'(done), 0);
    chk("idle/idx", 32'(step_idx), 0);

    // Single step, then two steps
    wr(0, 1, 7, 4);
    play(1, 1'b0, 1, "single");
    wr(0, 1, 7, 2);
    wr(1, 0, 3, 3);
    play(2, 1'b0, 1, "two");

    // Looping: two full passes, then stop mid-run
    play(2, 1'b1, 2, "loop");
    tick();
    wait_co(33, "loop3");
    repeat (4) tick();
    do_stop("loop");
    saw_done = 0;
    repeat (40) begin
      tick();
      if (done === 1'b1) saw_done = 1;
    end
    chk("loop/never_done", 32'(saw_done), 0);

    // dur = 0 plays 256 carries
    wr(0, 1, 7, 0);
    play(1, 1'b0, 1, "dur0");

    // start and stop together in IDLE
    start = 1'b1;
    stop  = 1'b1;
    tick();
    start = 1'b0;
    stop  = 1'b0;
    chk("ss/busy", 32'(busy), 0);
    tick();
    chk("ss/busy2", 32'(busy), 0);
    chk("ss/init", 32'(div_init), 1);

    // start while running is ignored
    wr(0, 1, 7, 3);
    last_idx = 3'd0;
    loop     = 1'b0;
    start    = 1'b1;
    tick();
    start    = 1'b0;
    tick();
    wait_co(33, "restart1");
    repeat (3) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("restart/busy", 32'(busy), 1);
    chk("restart/idx", 32'(step_idx), 0);
    chk("restart/init", 32'(div_init), 0);
    wait_co(28, "restart2");
    wait_co(32, "restart3");
    chk("restart/done", 32'(done), 1);
    tick();

    // Write to the current step only lands at its next LOAD
    wr(0, 1, 7, 2);
    last_idx = 3'd0;
    loop     = 1'b1;
    start    = 1'b1;
    tick();
    start    = 1'b0;
    tick();
    chk("wcur/sw0", 32'(div_sw), 7);
    wait_co(33, "wcur1");
    wr(0, 1, 5, 1);
    chk("wcur/sw_hold", 32'(div_sw), 7);
    wait_co(31, "wcur2");
    chk("wcur/idx", 32'(step_idx), 0);
    tick();
    chk("wcur/sw_new", 32'(div_sw), 5);
    wait_co(97, "wcur3");
    tick();
    chk("wcur/sw_again", 32'(div_sw), 5);
    tick();
    do_stop("wcur");

    // Randomized step lists
    for (int it = 0; it < 5; it++) begin
      n = int'($urandom_range(1, 3));
      for (int s = 0; s < n; s++) begin
        h = ($urandom_range(0, 3) == 0) ? 0 : 1;
        wr(s, h, int'($urandom_range(0, 7)), int'($urandom_range(1, 2)));
      end
      lp = 1'($urandom_range(0, 1));
      if (lp) begin
        play(n, 1'b1, 2, "rand_loop");
        tick();
        do_stop("rand_loop");
      end else begin
        play(n, 1'b0, 1, "rand");
      end
      tick();
    end

    // Asynchronous reset in the middle of a run
    wr(0, 1, 7, 3);
    last_idx = 3'd0;
    loop     = 1'b1;
    start    = 1'b1;
    tick();
    start    = 1'b0;
    tick();
    wait_co(33, "arst");
    #2;
    rst = 1'b0;
    #1;
    chk("arst/busy", 32'(busy), 0);
    chk("arst/init", 32'(div_init), 1);
    chk("arst/tone", 32'(tone_out), 0);
    chk("arst/idx", 32'(step_idx), 0);
    chk("arst/done", 32'(done), 0);
    tick();
    rst = 1'b1;
    repeat (5) tick();
    chk("arst/idle", 32'(busy), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/tone_sequencer.md
Name: tone_sequencer

Overview:
- Sequences the 9-bit frequency divider through a programmable list of tone steps.
- Each step sets the divider's H_L/SW inputs and holds them for a set number of divider carry-out pulses.
- Toggles a square-wave tone output on every carry-out.
- Sits between the board switch/control logic and the divider; owns the divider's init, H_L and SW inputs, and consumes its co.

Parameters:
- STEPS, 8, number of table entries; index width is log2(STEPS).
- DUR_W, 8, width of each step's duration field, in carry-out pulses.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst  input  1  asynchronous, active-low reset (asserted at 0).
- wr_en  input  1  table write strobe.
- wr_addr  input  3  table entry to write.
- wr_data  input  4+DUR_W  {hl[1], sw[3], dur[DUR_W]}.
- last_idx  input  3  index of the final step played.
- loop  input  1  1 = restart at step 0 after last_idx.
- start  input  1  single-cycle request to begin playback.
- stop  input  1  single-cycle abort.
- div_co  input  1  divider carry-out: one-cycle pulse every 512 - {hl,sw,5'b0} clocks after init falls.
- div_init  output  1  divider reload.
- div_hl  output  1  divider H_L.
- div_sw  output  3  divider SW.
- tone_out  output  1  square wave, toggles on each counted div_co.
- busy  output  1  high in LOAD/RUN.
- done  output  1  one-cycle pulse at natural end of a non-looping sequence.
- step_idx  output  3  current step.

Behaviour:
- All outputs are registered.
- Reset values: div_init=1, div_hl=0, div_sw=0, tone_out=0, busy=0, done=0, step_idx=0, state IDLE.
- Reset mid-operation returns to IDLE immediately. Table contents are undefined after reset.
- Table writes:
  - Accepted in every state, one cycle to take effect.
  - A write to the current step takes effect only at that step's next LOAD.
- IDLE:
  - div_init=1, tone_out=0, busy=0.
  - start (with stop low) -> LOAD with idx=0.
- LOAD (exactly 1 cycle):
  - div_hl/div_sw <= table[idx].hl/sw, div_init=1, dur_cnt <= table[idx].dur, busy=1.
  - Next state RUN.
  - Latency: start sampled at edge k, new settings visible after edge k+1, div_init low after edge k+2.
- RUN (div_init=0) on each div_co:
  - tone_out toggles.
  - If dur_cnt != 1: dur_cnt decrements.
  - If dur_cnt == 1 and idx != last_idx: idx+1, go to LOAD.
  - If dur_cnt == 1, idx == last_idx and loop=1: idx=0, go to LOAD.
  - If dur_cnt == 1, idx == last_idx and loop=0: go to DONE.
- dur=0 means 2^DUR_W pulses (natural wrap of the decrement).
- DONE (1 cycle): done=1, busy=0, tone_out<=0, div_init=1, then IDLE.
- stop:
  - In LOAD/RUN: next state IDLE, no done pulse, tone_out<=0, div_init<=1, idx<=0.
  - stop has priority over start and over div_co in the same cycle.
  - start while busy is ignored.
- div_co arriving during LOAD is ignored; the divider is held in init then.
- last_idx >= STEPS: compare uses the low index bits only, so behaviour wraps naturally.
- div_hl/div_sw hold their last value through DONE/IDLE.

Decomposition:
- Shared package tone_pkg:
  - STEPS, DUR_W, IDX_W.
  - Step record field offsets (HL_BIT, SW_MSB/LSB, DUR_MSB/LSB).
  - State encoding: IDLE, LOAD, RUN, DONE.
- One sub-module, step_table: STEPS x (4+DUR_W) register file with a synchronous write port and an asynchronous read port addressed by idx.
- Top holds the FSM, duration counter and tone flop.

Test Plan:
- Reset: hold rst=0 -> div_init=1, tone_out=0, busy=0, done=0, step_idx=0. Release, idle 20 cycles -> outputs unchanged.
- Single step {hl=1, sw=7, dur=4}, last_idx=0, loop=0, start:
  - div_hl=1, sw=7 and div_init pulse after edge k+1.
  - 4 div_co pulses spaced 32 clocks; tone_out toggles 4 times.
  - done=1 for exactly one cycle after the 4th co, busy falls with it, tone_out=0.
- Two steps {1,7,2}, {0,3,3}, last_idx=1:
  - step_idx goes 0->1 after the 2nd co.
  - One-cycle div_init, then div_sw=3 with co spacing 512-96=416.
  - done after the 3rd co of step 1.
- loop=1, same two steps: idx returns to 0 after the last co with no done. Then stop mid-RUN -> IDLE next cycle, busy=0, done never asserted, tone_out=0.
- dur=0 single step -> exactly 256 co pulses counted before done.
- Arbitration:
  - start and stop in the same cycle in IDLE -> stays IDLE.
  - start during RUN -> ignored, step_idx unchanged.
  - Write to the current step during RUN -> applied only on the next LOAD of that step.
